// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, csr_op encodings, mstatus bit positions, cause codes.
package csr_pkg;

   localparam int unsigned XLEN_W    = 32;
   localparam int unsigned CSR_ADDR_W = 12;
   localparam int unsigned CNT_W     = 64;

   typedef logic [CSR_ADDR_W-1:0] csr_addr_t;

   localparam csr_addr_t CSR_MSTATUS   = 12'h300;
   localparam csr_addr_t CSR_MISA      = 12'h301;
   localparam csr_addr_t CSR_MTVEC     = 12'h305;
   localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
   localparam csr_addr_t CSR_MEPC      = 12'h341;
   localparam csr_addr_t CSR_MCAUSE    = 12'h342;
   localparam csr_addr_t CSR_MTVAL     = 12'h343;
   localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
   localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
   localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
   localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
   localparam csr_addr_t CSR_MVENDORID = 12'hF11;
   localparam csr_addr_t CSR_MARCHID   = 12'hF12;
   localparam csr_addr_t CSR_MIMPID    = 12'hF13;
   localparam csr_addr_t CSR_MHARTID   = 12'hF14;

   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   localparam logic [XLEN_W-1:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [XLEN_W-1:0] CAUSE_ECALL_M = 32'd11;

   typedef enum logic {
      ST_NORMAL   = 1'b0,
      ST_REDIRECT = 1'b1
   } trap_state_e;

   // Read-modify-write value for a CSR instruction given the pre-write value.
   function automatic logic [XLEN_W-1:0] csr_apply(input logic [1:0] op,
                                                   input logic [XLEN_W-1:0] old,
                                                   input logic [XLEN_W-1:0] wdata);
      logic [XLEN_W-1:0] res;
      res = old;
      case (op)
         CSR_OP_RW: res = wdata;
         CSR_OP_RS: res = old | wdata;
         CSR_OP_RC: res = old & ~wdata;
         default:   res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with increment enable and independent 32-bit
// half writes; a write to either half suppresses that cycle's increment.
module csr_counter64
   import csr_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_en,
   input  logic              wr_lo,
   input  logic              wr_hi,
   input  logic [XLEN_W-1:0] wdata,
   output logic [CNT_W-1:0]  count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (wr_lo || wr_hi) begin
         if (wr_lo) count[XLEN_W-1:0]     <= wdata;
         if (wr_hi) count[CNT_W-1:XLEN_W] <= wdata;
      end else if (inc_en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap sequencer: CSR read/modify/write, trap entry,
// mret, and a registered one-cycle PC redirect to fetch.
module trap_csr_unit
   import csr_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csr_en,
   input  logic [1:0]      csr_op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   input  logic            exc_en,
   input  logic [XLEN-1:0] exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] exc_tval,
   input  logic            mret,
   input  logic            instr_retire,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mie_out
);

   logic            mie_q;
   logic            mpie_q;
   logic [XLEN-1:0] mtvec_q;
   logic [XLEN-1:0] mscratch_q;
   logic [XLEN-1:0] mepc_q;
   logic [XLEN-1:0] mcause_q;
   logic [XLEN-1:0] mtval_q;
   logic [CNT_W-1:0] mcycle;
   logic [CNT_W-1:0] minstret;

   logic [XLEN-1:0] mstatus_val;
   logic            addr_known;
   logic            addr_ro;
   logic            write_req;
   logic            csr_we;
   logic [XLEN-1:0] wval;

   trap_state_e     state_q;
   trap_state_e     state_d;
   logic [XLEN-1:0] redirect_pc_d;

   always_comb begin
      mstatus_val               = '0;
      mstatus_val[MSTATUS_MIE]  = mie_q;
      mstatus_val[MSTATUS_MPIE] = mpie_q;
   end

   // Read mux; unknown addresses read as zero and flag addr_known=0.
   always_comb begin
      csr_rdata  = '0;
      addr_known = 1'b1;
      case (csr_addr)
         CSR_MSTATUS:   csr_rdata = mstatus_val;
         CSR_MISA:      csr_rdata = MISA_VAL;
         CSR_MTVEC:     csr_rdata = mtvec_q;
         CSR_MSCRATCH:  csr_rdata = mscratch_q;
         CSR_MEPC:      csr_rdata = mepc_q;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MTVAL:     csr_rdata = mtval_q;
         CSR_MCYCLE:    csr_rdata = mcycle[XLEN_W-1:0];
         CSR_MCYCLEH:   csr_rdata = mcycle[CNT_W-1:XLEN_W];
         CSR_MINSTRET:  csr_rdata = minstret[XLEN_W-1:0];
         CSR_MINSTRETH: csr_rdata = minstret[CNT_W-1:XLEN_W];
         CSR_MVENDORID, CSR_MARCHID,
         CSR_MIMPID, CSR_MHARTID: csr_rdata = '0;
         default:       addr_known = 1'b0;
      endcase
   end

   // RS/RC with a zero mask is a pure read and never counts as a write.
   assign write_req = csr_en &&
                      ((csr_op == CSR_OP_RW) ||
                       (((csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC)) && (|csr_wdata)));
   assign addr_ro     = (csr_addr[11:10] == 2'b11) || (csr_addr == CSR_MISA);
   assign csr_illegal = csr_en && (!addr_known || (write_req && addr_ro));
   assign csr_we      = write_req && !csr_illegal && !exc_en && !mret;
   assign wval        = csr_apply(csr_op, csr_rdata, csr_wdata);

   // Architectural CSR state: trap entry, then mret, then CSR writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= {RESET_MTVEC[XLEN-1:2], 2'b00};
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
      end else if (exc_en) begin
         mepc_q   <= {exc_pc[XLEN-1:2], 2'b00};
         mcause_q <= exc_cause;
         mtval_q  <= exc_tval;
         mpie_q   <= mie_q;
         mie_q    <= 1'b0;
      end else if (mret) begin
         mie_q  <= mpie_q;
         mpie_q <= 1'b1;
      end else if (csr_we) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mie_q  <= wval[MSTATUS_MIE];
               mpie_q <= wval[MSTATUS_MPIE];
            end
            CSR_MTVEC:    mtvec_q    <= {wval[XLEN-1:2], 2'b00};
            CSR_MSCRATCH: mscratch_q <= wval;
            CSR_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_q   <= wval;
            CSR_MTVAL:    mtval_q    <= wval;
            default: ;
         endcase
      end
   end

   csr_counter64 u_mcycle (
      .clk    (clk),
      .rst    (rst),
      .inc_en (1'b1),
      .wr_lo  (csr_we && (csr_addr == CSR_MCYCLE)),
      .wr_hi  (csr_we && (csr_addr == CSR_MCYCLEH)),
      .wdata  (wval),
      .count  (mcycle)
   );

   csr_counter64 u_minstret (
      .clk    (clk),
      .rst    (rst),
      .inc_en (instr_retire),
      .wr_lo  (csr_we && (csr_addr == CSR_MINSTRET)),
      .wr_hi  (csr_we && (csr_addr == CSR_MINSTRETH)),
      .wdata  (wval),
      .count  (minstret)
   );

   // Redirect sequencer state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_NORMAL;
         redirect_pc <= '0;
      end else begin
         state_q     <= state_d;
         redirect_pc <= redirect_pc_d;
      end
   end

   // Both states leave on the same events; REDIRECT lasts one cycle per event.
   always_comb begin
      state_d       = ST_NORMAL;
      redirect_pc_d = redirect_pc;
      case (state_q)
         ST_NORMAL, ST_REDIRECT: begin
            if (exc_en) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = mtvec_q;
            end else if (mret) begin
               state_d       = ST_REDIRECT;
               redirect_pc_d = mepc_q;
            end
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   assign redirect_valid = (state_q == ST_REDIRECT);
   assign mie_out        = mie_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed self-checking bench for trap_csr_unit: CSR access, trap entry,
// mret, priority, counters, illegal detection and reset override.
module tb_trap_csr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        csr_en;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic        exc_en;
   logic [31:0] exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] exc_tval;
   logic        mret;
   logic        instr_retire;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        mie_out;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   trap_csr_unit dut (
      .clk            (clk),
      .rst            (rst),
      .csr_en         (csr_en),
      .csr_op         (csr_op),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata),
      .csr_rdata      (csr_rdata),
      .csr_illegal    (csr_illegal),
      .exc_en         (exc_en),
      .exc_cause      (exc_cause),
      .exc_pc         (exc_pc),
      .exc_tval       (exc_tval),
      .mret           (mret),
      .instr_retire   (instr_retire),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mie_out        (mie_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      csr_en       = 1'b0;
      csr_op       = 2'b00;
      csr_addr     = 12'h000;
      csr_wdata    = '0;
      exc_en       = 1'b0;
      exc_cause    = '0;
      exc_pc       = '0;
      exc_tval     = '0;
      mret         = 1'b0;
   endtask

   task automatic csr_set(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      csr_en    = 1'b1;
      csr_op    = op;
      csr_addr  = addr;
      csr_wdata = wd;
   endtask

   // CSRRS with a zero mask: read only, consumes one cycle.
   task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
      csr_set(2'b10, addr, 32'h0);
      #1;
      chk(tag, csr_rdata, exp);
      tick();
      csr_en = 1'b0;
   endtask

   task automatic wr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
      csr_set(op, addr, wd);
      tick();
      csr_en = 1'b0;
   endtask

   initial begin
      clear_inputs();
      instr_retire = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_mie_out", 32'(mie_out), 32'h0);
      rd("rst_mstatus", 12'h300, 32'h0);
      rd("rst_mtvec", 12'h305, 32'h0);
      rd("misa", 12'h301, 32'h4000_0100);

      // mtvec write drops low bits; rdata shows pre-write value
      csr_set(2'b01, 12'h305, 32'h0000_0103);
      #1;
      chk("mtvec_old_rdata", csr_rdata, 32'h0);
      chk("mtvec_wr_legal", 32'(csr_illegal), 32'h0);
      tick();
      csr_en = 1'b0;
      rd("mtvec_readback", 12'h305, 32'h0000_0100);

      wr(2'b10, 12'h300, 32'h8);
      chk("mie_set", 32'(mie_out), 32'h1);
      rd("mstatus_mie", 12'h300, 32'h8);

      // trap entry
      exc_en = 1'b1; exc_cause = 32'd2; exc_pc = 32'h18; exc_tval = 32'h3020_0073;
      tick();
      clear_inputs();
      chk("trap_valid", 32'(redirect_valid), 32'h1);
      chk("trap_pc", redirect_pc, 32'h100);
      chk("trap_mie_clr", 32'(mie_out), 32'h0);
      rd("trap_mepc", 12'h341, 32'h18);
      chk("trap_pulse_width", 32'(redirect_valid), 32'h0);
      rd("trap_mcause", 12'h342, 32'h2);
      rd("trap_mtval", 12'h343, 32'h3020_0073);
      rd("trap_mstatus", 12'h300, 32'h80);

      // mret
      mret = 1'b1;
      tick();
      mret = 1'b0;
      chk("mret_valid", 32'(redirect_valid), 32'h1);
      chk("mret_pc", redirect_pc, 32'h18);
      rd("mret_mstatus", 12'h300, 32'h88);
      chk("mret_pulse_width", 32'(redirect_valid), 32'h0);

      // exc_en beats mret in the same cycle
      exc_en = 1'b1; mret = 1'b1; exc_cause = 32'd11; exc_pc = 32'h207; exc_tval = 32'h0;
      tick();
      clear_inputs();
      chk("prio_valid", 32'(redirect_valid), 32'h1);
      chk("prio_pc", redirect_pc, 32'h100);
      rd("prio_mepc", 12'h341, 32'h204);
      rd("prio_mcause", 12'h342, 32'd11);
      rd("prio_mstatus", 12'h300, 32'h80);

      // mret drops a same-cycle mepc write and uses the old mepc
      mret = 1'b1;
      csr_set(2'b01, 12'h341, 32'h500);
      tick();
      clear_inputs();
      chk("mret_wr_pc", redirect_pc, 32'h204);
      rd("mret_wr_mepc", 12'h341, 32'h204);
      rd("mret_wr_mstatus", 12'h300, 32'h88);

      // back-to-back trap then mret
      exc_en = 1'b1; exc_cause = 32'd2; exc_pc = 32'h40;
      tick();
      clear_inputs();
      mret = 1'b1;
      chk("b2b_valid0", 32'(redirect_valid), 32'h1);
      chk("b2b_pc0", redirect_pc, 32'h100);
      tick();
      mret = 1'b0;
      chk("b2b_valid1", 32'(redirect_valid), 32'h1);
      chk("b2b_pc1", redirect_pc, 32'h40);
      tick();
      chk("b2b_end", 32'(redirect_valid), 32'h0);

      // mcycle half writes, then carry from the next increment
      wr(2'b01, 12'hB00, 32'hFFFF_FFFF);
      wr(2'b01, 12'hB80, 32'h0);
      tick();
      rd("mcycleh_carry", 12'hB80, 32'h1);
      rd("mcycle_lo", 12'hB00, 32'h1);

      rd("minstret_zero", 12'hB02, 32'h0);
      instr_retire = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      instr_retire = 1'b0;
      rd("minstret_5", 12'hB02, 32'h5);
      rd("minstreth", 12'hB82, 32'h0);

      // illegal accesses
      wr(2'b01, 12'h340, 32'hA5A5_0001);
      rd("mscratch", 12'h340, 32'hA5A5_0001);
      csr_set(2'b01, 12'hF14, 32'h5);
      #1;
      chk("ro_write_illegal", 32'(csr_illegal), 32'h1);
      tick();
      csr_set(2'b01, 12'h7C0, 32'h1);
      #1;
      chk("unknown_illegal", 32'(csr_illegal), 32'h1);
      tick();
      csr_set(2'b10, 12'hF14, 32'h0);
      #1;
      chk("ro_read_legal", 32'(csr_illegal), 32'h0);
      tick();
      csr_set(2'b10, 12'hF14, 32'h4);
      #1;
      chk("ro_set_illegal", 32'(csr_illegal), 32'h1);
      tick();
      csr_en = 1'b0;
      rd("mscratch_kept", 12'h340, 32'hA5A5_0001);
      wr(2'b11, 12'h340, 32'h1);
      rd("mscratch_rc", 12'h340, 32'hA5A5_0000);

      // reset wins over a same-cycle trap
      exc_en = 1'b1; exc_cause = 32'd2; exc_pc = 32'h80;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_inputs();
      chk("rst_over_valid", 32'(redirect_valid), 32'h0);
      chk("rst_over_pc", redirect_pc, 32'h0);
      rd("rst_mcycle", 12'hB00, 32'h0);
      rd("rst_mtvec2", 12'h305, 32'h0);
      rd("rst_mepc", 12'h341, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
Machine-mode CSR file and trap sequencer for the single-issue RV32 core; sits beside execute, consuming CSR instructions, exception requests (exc_en) and mret from decode/execute.
Produces a registered PC redirect to fetch on trap entry and return.
Holds mstatus, mtvec, mscratch, mepc, mcause, mtval and the 64-bit mcycle/minstret counters.
cpu_top instantiates it as u_csr.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RESET_MTVEC, 32'h0000_0000, mtvec value after reset; bits[1:0] are forced to 0.
MISA_VAL, 32'h4000_0100, read-only misa value (RV32I).

Ports:
clk  in  1  core clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
csr_en  in  1  CSR instruction valid this cycle
csr_op  in  2  01=RW, 10=RS, 11=RC; 00 is treated as no-op
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  rs1 value or zero-extended uimm, selected by decode
csr_rdata  out  XLEN  combinational old value of csr_addr
csr_illegal  out  1  combinational; csr_en with an unknown address, or a write to a read-only address
exc_en  in  1  exception request (single-cycle pulse)
exc_cause  in  XLEN  mcause value for the exception
exc_pc  in  XLEN  PC of the faulting instruction
exc_tval  in  XLEN  mtval value
mret  in  1  mret executed this cycle
instr_retire  in  1  one instruction retired this cycle
redirect_valid  out  1  registered one-cycle pulse: fetch must jump
redirect_pc  out  XLEN  registered target, valid while redirect_valid=1
mie_out  out  1  mstatus.MIE

Behaviour:
- Reset (rst=1 at posedge):
  - mstatus=0, so MIE=0 and MPIE=0.
  - mtvec=RESET_MTVEC; mscratch, mepc, mcause, mtval=0.
  - mcycle and minstret=0.
  - redirect_valid=0, redirect_pc=0.
  - Reset overrides every other input in the same cycle, including a redirect already being generated.
- Address map:
  - 0x300 mstatus: only bit3 (MIE) and bit7 (MPIE) are writable; all other bits read 0.
  - 0x301 misa: read-only, returns MISA_VAL.
  - 0x305 mtvec: direct mode only; wdata[1:0] is ignored and stored as 0.
  - 0x340 mscratch.
  - 0x341 mepc: bits[1:0] are stored as 0.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0xB00/0xB80 mcycle low/high; 0xB02/0xB82 minstret low/high.
  - Any address with addr[11:10]==2'b11 is read-only; writing one raises csr_illegal.
- CSR write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - RS/RC with wdata==0 performs no write and cannot raise csr_illegal for a read-only address.
  - The write commits at the posedge; csr_rdata always reflects the pre-write value.
- When csr_illegal=1 no CSR state changes. Decode turns csr_illegal into exc_en (cause 2) in a following cycle.
- Trap entry (exc_en=1), at the posedge:
  - mepc=exc_pc with bits[1:0] cleared; mcause=exc_cause; mtval=exc_tval.
  - MPIE=MIE, then MIE=0.
  - redirect_valid=1 and redirect_pc=mtvec, both in the next cycle (1-cycle latency).
- mret (mret=1, exc_en=0), at the posedge:
  - MIE=MPIE, then MPIE=1.
  - redirect_valid=1 and redirect_pc=mepc, next cycle.
- Same-cycle priority: exc_en > mret > CSR write.
  - A lower-priority request in the same cycle is dropped entirely.
  - A CSR write to mepc in the same cycle as mret is dropped; the redirect uses the old mepc.
- redirect_valid stays high for exactly one cycle unless a new exc_en/mret arrives. Back-to-back events give back-to-back pulses with the updated target.
- Counters:
  - mcycle increments by 1 every non-reset cycle; minstret increments by 1 when instr_retire=1.
  - Both are 64-bit and wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A CSR write to either half takes precedence over that counter's increment in the same cycle; the other half is untouched and no carry is applied.
  - The counter addresses are 0xBxx, so they are writable here (addr[11:10]=2'b10).
- Nested trap: exc_en during the redirect cycle is handled normally and overwrites mepc/mcause.
- FSM, states NORMAL and REDIRECT:
  - NORMAL -> REDIRECT on exc_en|mret.
  - REDIRECT -> NORMAL otherwise; REDIRECT -> REDIRECT on a new exc_en|mret.
  - redirect_valid is high only in REDIRECT.

Decomposition:
- Shared package csr_pkg:
  - CSR address localparams (CSR_MSTATUS, CSR_MTVEC, ...).
  - csr_op encodings (CSR_OP_RW/RS/RC).
  - mstatus bit indices (MSTATUS_MIE=3, MSTATUS_MPIE=7).
  - Cause codes (CAUSE_ILLEGAL=2, CAUSE_ECALL_M=11).
- One sub-module, csr_counter64: 64-bit counter with an increment enable and independent lo/hi write ports. It is instantiated twice, for mcycle and minstret.

Test Plan:
- rst held 2 cycles, then CSRRW 0x305 with wdata 0x0000_0103 -> read of 0x305 returns 0x0000_0100; read of 0x300 returns 0.
- Set MIE via RS 0x300 with wdata 0x8; pulse exc_en with cause=2, pc=0x0000_0018, tval=0x30200073 -> next cycle redirect_valid=1 and redirect_pc=0x100; mepc=0x18, mcause=2, mtstatus reads 0x80 (MPIE=1, MIE=0); pulse width is 1 cycle.
- Then pulse mret -> next cycle redirect_pc=0x18; mstatus reads 0x88.
- exc_en and mret in the same cycle (mtvec=0x100, mepc=0x18) -> redirect_pc=0x100 and mepc=exc_pc.
- CSRRW 0xB00 with wdata 0xFFFF_FFFF and 0xB80 with 0 -> two cycles later mcycleh=1 and mcycle low is small; instr_retire held 5 cycles -> minstret=5.
- CSRRW to 0xF14, or to unknown 0x7C0 -> csr_illegal=1 and no state change; CSRRS to 0xF14 with wdata 0 -> csr_illegal=0.
